lbs_region_mux: RTL and testbench
=================================

# lbs_region_mux

Parametrised local-bus address decoder and read-back multiplexer for the lbs_clk register space. It sits between the host local bus and N_REGION client blocks (DDC capture RAM, DUC baseband RAM, command registers, and later additions). It generates registered per-region strobes and region-relative offsets, returns read data through a fixed two-stage pipeline, and owns a small built-in control window: ID, scratch, unmapped-access counter and sticky status.

## Interface
Parameters:
- AW, 16, address width
- DW, 32, data width
- N_REGION, 4, number of client regions (1..16)
- REGION_BASE, {N_REGION{16'h0}}, packed N_REGION*AW, first address of region i at bits [i*AW +: AW]
- REGION_LAST, {N_REGION{16'h0}}, packed N_REGION*AW, last address of region i, inclusive
- CTRL_BASE, 16'hFF00, base of the 4-word control window
- ID_VALUE, 32'h4C42_5301, value of the ID register

Ports (reset rst_n, asynchronous, active-low; clock lbs_clk):
- lbs_clk  in  1  local-bus clock
- rst_n  in  1  asynchronous active-low reset
- lbs_addr  in  AW  bus address
- lbs_din  in  DW  bus write data
- lbs_we  in  1  write strobe, one cycle per access
- lbs_re  in  1  read strobe, one cycle per access
- lbs_dout  out  DW  registered read data
- lbs_rvalid  out  1  one-cycle pulse aligned with valid lbs_dout
- reg_we  out  N_REGION  per-region registered write strobe
- reg_re  out  N_REGION  per-region registered read strobe
- reg_addr  out  AW  lbs_addr minus base of the hit region, registered
- reg_wdata  out  DW  registered lbs_din
- reg_rdata  in  N_REGION*DW  client read data, region i at [i*DW +: DW]
- err_irq  out  1  OR of unmasked sticky status bits, registered

## Operation
- Stage 1, at edge k where lbs_we or lbs_re is sampled:
  - Compute the hit vector: base_i <= addr <= last_i.
  - On overlapping regions, the lowest index wins (one-hot select).
  - Register reg_we/reg_re for one cycle only on the winning bit.
  - Register reg_addr = addr - base_win (AW bits, no wrap possible inside a region) and reg_wdata.
- Stage 2, at edge k+1:
  - lbs_dout <= reg_rdata of the registered winner, or the control-window word, or 0 if unmapped.
  - lbs_rvalid pulses only for reads.
- Control window, addresses CTRL_BASE+0..3, checked before the regions:
  - +0 ID (RO).
  - +1 SCRATCH (RW).
  - +2 ERR_CNT (RO; any write clears it). 16-bit saturating count of unmapped accesses, returned in [15:0], upper bits 0.
  - +3 STATUS, W1C sticky bits: [0] unmapped access, [1] overlap hit (more than one region matched), [2] we and re in the same cycle. Bits [18:16] are the RW irq mask, reset value 3'b111 (all masked).
  - Control accesses never assert reg_we/reg_re.
- Simultaneous lbs_we and lbs_re:
  - Both strobes are forwarded to the winner.
  - A read is returned.
  - STATUS[2] sets.
- Unmapped access:
  - No strobes.
  - Read returns 0.
  - STATUS[0] sets; ERR_CNT increments unless at 16'hFFFF.
- Same-cycle conflicts:
  - Event setting a STATUS bit and a W1C write to that bit in the same cycle: set wins.
  - ERR_CNT clear-write while an unmapped access increments it: impossible in the same cycle (a single bus access per cycle).
- Back-to-back accesses on consecutive cycles are fully supported; the pipeline holds no stall.

## Timing
- Reset values:
  - lbs_dout = 0, lbs_rvalid = 0, reg_we = 0, reg_re = 0, reg_addr = 0, reg_wdata = 0, err_irq = 0.
  - SCRATCH = 0, ERR_CNT = 0, STATUS = 0, mask = 3'b111.
- Latency:
  - Client strobes: 1 cycle after the bus strobe.
  - lbs_dout/lbs_rvalid: 2 cycles after lbs_re.
  - Clients present reg_rdata combinationally or registered from reg_addr within 1 cycle.
- err_irq follows STATUS/mask with 1 cycle of delay.
- Reset asserted mid-access: pipeline cleared, and a pending strobe is dropped, not replayed.

## Configuration
- LBS_MUX_ERR_CNT_EN:
  - Defined: ERR_CNT is implemented as above.
  - Undefined: the counter logic is removed; +2 reads 0 and writes are ignored. STATUS is unaffected.

## Structure
- Package lbs_mux_pkg:
  - Control offsets CTRL_ID=0, CTRL_SCRATCH=1, CTRL_ERRCNT=2, CTRL_STATUS=3.
  - STATUS bit indices.
  - ERRCNT_W=16.
- One sub-module, lbs_region_dec: combinational hit vector plus lowest-index priority encoder, with an overlap flag; instantiated once.

## Test plan
- REGION_BASE/LAST = {0..11520, 11521..11521, 12000..14304, 16000..16000}. Read 12005 -> reg_re = 4'b0100 at k+1, reg_addr = 5; lbs_dout = reg_rdata[2] at k+2 with lbs_rvalid = 1.
- Write 32'h1234_5678 to CTRL_BASE+1, then read it -> lbs_dout = 32'h1234_5678, and no reg_we bit set.
- Read 20000 three times -> lbs_dout = 0, ERR_CNT = 3, STATUS[0] = 1. Unmask bit 0 -> err_irq = 1. Write 1 to STATUS[0] -> err_irq = 0.
- Overlapping regions 0..100 and 50..200, read 60 -> reg_re = 4'b0001, reg_addr = 60, STATUS[1] = 1.
- Assert lbs_we and lbs_re together at 11521 -> reg_we[1] = reg_re[1] = 1, STATUS[2] = 1.
- Issue 70000 unmapped accesses -> ERR_CNT = 16'hFFFF. Rerun without LBS_MUX_ERR_CNT_EN -> CTRL_BASE+2 reads 0.

Source files
------------

// File: rtl/lbs_region_mux_pkg.sv
// lbs_mux_pkg: shared constants for the local-bus region decoder/mux.
// Control window word offsets, STATUS bit layout and error counter width.
package lbs_mux_pkg;

  // Control window word offsets relative to CTRL_BASE
  localparam logic [1:0] CTRL_ID      = 2'd0;
  localparam logic [1:0] CTRL_SCRATCH = 2'd1;
  localparam logic [1:0] CTRL_ERRCNT  = 2'd2;
  localparam logic [1:0] CTRL_STATUS  = 2'd3;

  // STATUS sticky bit indices (W1C) and irq mask position
  localparam int ST_UNMAPPED = 0;
  localparam int ST_OVERLAP  = 1;
  localparam int ST_WE_RE    = 2;
  localparam int ST_W        = 3;
  localparam int MASK_LSB    = 16;

  localparam int ERRCNT_W = 16;

  // Width of a region index; never zero so a single-region build still has a bit
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/lbs_region_mux_dec.sv
// lbs_region_dec: combinational region hit decode with lowest-index priority.
// Reports the one-hot winner, its index, whether anything hit, and whether
// more than one region matched the address.
module lbs_region_dec
  import lbs_mux_pkg::*;
#(
  parameter int AW       = 16,
  parameter int N_REGION = 4,
  parameter int IW       = 2,
  parameter logic [N_REGION*AW-1:0] REGION_BASE = '0,
  parameter logic [N_REGION*AW-1:0] REGION_LAST = '0
) (
  input  logic [AW-1:0]       addr,
  output logic [N_REGION-1:0] win_onehot,
  output logic [IW-1:0]       win_idx,
  output logic                any_hit,
  output logic                overlap
);

  logic [N_REGION-1:0] hit;

  // Range compare per region, then pick the lowest matching index
  always_comb begin
    logic found;
    hit     = '0;
    win_idx = '0;
    found   = 1'b0;
    for (int i = 0; i < N_REGION; i++) begin
      hit[i] = (addr >= REGION_BASE[i*AW +: AW]) && (addr <= REGION_LAST[i*AW +: AW]);
    end
    for (int i = 0; i < N_REGION; i++) begin
      if (hit[i] && !found) begin
        win_idx = IW'(i);
        found   = 1'b1;
      end
    end
    win_onehot = hit & (~hit + N_REGION'(1));
    any_hit    = |hit;
    overlap    = |(hit & ~win_onehot);
  end

endmodule

// File: rtl/lbs_region_mux.sv
// lbs_region_mux: local-bus address decoder and read-back multiplexer.
// Stage 1 registers per-region strobes/offset/wdata; stage 2 returns read data.
// Owns a 4-word control window (ID, SCRATCH, ERR_CNT, STATUS/mask).
// Optional macro LBS_MUX_ERR_CNT_EN builds the unmapped-access counter.
//
// Bus semantics: lbs_we/lbs_re are single-cycle strobes, one access per cycle,
// no back-pressure. Clients see reg_we/reg_re one cycle later, must present
// reg_rdata within that cycle; lbs_rvalid pulses with lbs_dout two cycles after lbs_re.
module lbs_region_mux
  import lbs_mux_pkg::*;
#(
  parameter int AW       = 16,
  parameter int DW       = 32,
  parameter int N_REGION = 4,
  parameter logic [N_REGION*AW-1:0] REGION_BASE = '0,
  parameter logic [N_REGION*AW-1:0] REGION_LAST = '0,
  parameter logic [AW-1:0] CTRL_BASE = 16'hFF00,
  parameter logic [DW-1:0] ID_VALUE  = 32'h4C42_5301
) (
  input  logic                   lbs_clk,
  input  logic                   rst_n,
  input  logic [AW-1:0]          lbs_addr,
  input  logic [DW-1:0]          lbs_din,
  input  logic                   lbs_we,
  input  logic                   lbs_re,
  output logic [DW-1:0]          lbs_dout,
  output logic                   lbs_rvalid,
  output logic [N_REGION-1:0]    reg_we,
  output logic [N_REGION-1:0]    reg_re,
  output logic [AW-1:0]          reg_addr,
  output logic [DW-1:0]          reg_wdata,
  input  logic [N_REGION*DW-1:0] reg_rdata,
  output logic                   err_irq
);

  localparam int IW = idx_w(N_REGION);

  logic [N_REGION-1:0] win_onehot;
  logic [IW-1:0]       win_idx;
  logic                any_hit;
  logic                overlap;

  lbs_region_dec #(
    .AW(AW), .N_REGION(N_REGION), .IW(IW),
    .REGION_BASE(REGION_BASE), .REGION_LAST(REGION_LAST)
  ) u_dec (
    .addr(lbs_addr), .win_onehot(win_onehot), .win_idx(win_idx),
    .any_hit(any_hit), .overlap(overlap)
  );

  logic          access, ctrl_hit, region_acc, unmapped, ctrl_wr;
  logic [AW-1:0] ctrl_off_full;
  logic [1:0]    ctrl_off;
  logic [AW-1:0] base_win;

  // Classify the current access; the control window takes precedence over regions
  always_comb begin
    access        = lbs_we | lbs_re;
    ctrl_off_full = lbs_addr - CTRL_BASE;
    ctrl_hit      = (ctrl_off_full < AW'(4));
    ctrl_off      = ctrl_off_full[1:0];
    region_acc    = access && !ctrl_hit && any_hit;
    unmapped      = access && !ctrl_hit && !any_hit;
    ctrl_wr       = lbs_we && ctrl_hit;
    base_win      = REGION_BASE[win_idx*AW +: AW];
  end

  logic          s1_read, s1_ctrl, s1_hit;
  logic [1:0]    s1_off;
  logic [IW-1:0] s1_idx;

  // Stage 1: client strobes, region offset, write data and read context
  always_ff @(posedge lbs_clk or negedge rst_n) begin
    if (!rst_n) begin
      reg_we    <= '0;
      reg_re    <= '0;
      reg_addr  <= '0;
      reg_wdata <= '0;
      s1_read   <= 1'b0;
      s1_ctrl   <= 1'b0;
      s1_hit    <= 1'b0;
      s1_off    <= '0;
      s1_idx    <= '0;
    end else begin
      reg_we  <= (lbs_we && region_acc) ? win_onehot : '0;
      reg_re  <= (lbs_re && region_acc) ? win_onehot : '0;
      s1_read <= lbs_re;
      if (region_acc) reg_addr <= lbs_addr - base_win;
      if (access) begin
        reg_wdata <= lbs_din;
        s1_ctrl   <= ctrl_hit;
        s1_hit    <= any_hit;
        s1_off    <= ctrl_off;
        s1_idx    <= win_idx;
      end
    end
  end

  logic [DW-1:0]       scratch;
  logic [ST_W-1:0]     status, status_set, status_clr;
  logic [ST_W-1:0]     irq_mask;
  logic [ERRCNT_W-1:0] err_cnt;

  // Sticky event sources and W1C clears; a same-cycle set overrides the clear
  always_comb begin
    status_set              = '0;
    status_set[ST_UNMAPPED] = unmapped;
    status_set[ST_OVERLAP]  = region_acc && overlap;
    status_set[ST_WE_RE]    = lbs_we && lbs_re;
    status_clr = (ctrl_wr && ctrl_off == CTRL_STATUS) ? lbs_din[ST_W-1:0] : '0;
  end

  // Control registers: SCRATCH, STATUS, irq mask and the registered irq
  always_ff @(posedge lbs_clk or negedge rst_n) begin
    if (!rst_n) begin
      scratch  <= '0;
      status   <= '0;
      irq_mask <= '1;
      err_irq  <= 1'b0;
    end else begin
      if (ctrl_wr && ctrl_off == CTRL_SCRATCH) scratch <= lbs_din;
      if (ctrl_wr && ctrl_off == CTRL_STATUS) irq_mask <= lbs_din[MASK_LSB +: ST_W];
      status  <= (status & ~status_clr) | status_set;
      err_irq <= |(status & ~irq_mask);
    end
  end

`ifdef LBS_MUX_ERR_CNT_EN
  // Saturating unmapped-access counter; any write to its word clears it
  always_ff @(posedge lbs_clk or negedge rst_n) begin
    if (!rst_n) begin
      err_cnt <= '0;
    end else if (ctrl_wr && ctrl_off == CTRL_ERRCNT) begin
      err_cnt <= '0;
    end else if (unmapped && err_cnt != '1) begin
      err_cnt <= err_cnt + 1'b1;
    end
  end
`else
  assign err_cnt = '0;
`endif

  logic [DW-1:0] ctrl_word;

  // Control window read-back word for the access held in stage 1
  always_comb begin
    ctrl_word = '0;
    case (s1_off)
      CTRL_ID:      ctrl_word = ID_VALUE;
      CTRL_SCRATCH: ctrl_word = scratch;
      CTRL_ERRCNT:  ctrl_word[ERRCNT_W-1:0] = err_cnt;
      default: begin
        ctrl_word[ST_W-1:0]          = status;
        ctrl_word[MASK_LSB +: ST_W]  = irq_mask;
      end
    endcase
  end

  // Stage 2: read data return and valid pulse
  always_ff @(posedge lbs_clk or negedge rst_n) begin
    if (!rst_n) begin
      lbs_dout   <= '0;
      lbs_rvalid <= 1'b0;
    end else begin
      lbs_rvalid <= s1_read;
      if (s1_read) begin
        if (s1_ctrl)     lbs_dout <= ctrl_word;
        else if (s1_hit) lbs_dout <= reg_rdata[s1_idx*DW +: DW];
        else             lbs_dout <= '0;
      end
    end
  end

endmodule

// File: tb/tb_lbs_region_mux.sv
// tb_lbs_region_mux: directed test of lbs_region_mux with hand-computed
// expectations. Main instance uses four disjoint regions; a second instance
// has two overlapping regions. Honours LBS_MUX_ERR_CNT_EN when defined.
module tb_lbs_region_mux;

`ifdef LBS_MUX_ERR_CNT_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // ---------------- main instance ----------------
  logic [15:0]  lbs_addr = '0;
  logic [31:0]  lbs_din = '0;
  logic         lbs_we = 1'b0, lbs_re = 1'b0;
  logic [31:0]  lbs_dout;
  logic         lbs_rvalid;
  logic [3:0]   reg_we, reg_re;
  logic [15:0]  reg_addr;
  logic [31:0]  reg_wdata;
  logic [127:0] reg_rdata;
  logic         err_irq;

  // Client model: region i returns {A0+i, 00, reg_addr}
  assign reg_rdata = {8'hA3, 8'h00, reg_addr, 8'hA2, 8'h00, reg_addr,
                      8'hA1, 8'h00, reg_addr, 8'hA0, 8'h00, reg_addr};

  lbs_region_mux #(
    .N_REGION(4),
    .REGION_BASE({16'd16000, 16'd12000, 16'd11521, 16'd0}),
    .REGION_LAST({16'd16000, 16'd14304, 16'd11521, 16'd11520})
  ) u_dut (
    .lbs_clk(clk), .rst_n(rst_n), .lbs_addr(lbs_addr), .lbs_din(lbs_din),
    .lbs_we(lbs_we), .lbs_re(lbs_re), .lbs_dout(lbs_dout), .lbs_rvalid(lbs_rvalid),
    .reg_we(reg_we), .reg_re(reg_re), .reg_addr(reg_addr), .reg_wdata(reg_wdata),
    .reg_rdata(reg_rdata), .err_irq(err_irq)
  );

  // ---------------- overlap instance ----------------
  logic [15:0] o_addr = '0;
  logic [31:0] o_din = '0;
  logic        o_we = 1'b0, o_re = 1'b0;
  logic [31:0] o_dout;
  logic        o_rvalid;
  logic [1:0]  o_reg_we, o_reg_re;
  logic [15:0] o_reg_addr;
  logic [31:0] o_reg_wdata;
  logic [63:0] o_rdata;
  logic        o_irq;

  assign o_rdata = {32'hB1B1_B1B1, 32'hB0B0_B0B0};

  lbs_region_mux #(
    .N_REGION(2),
    .REGION_BASE({16'd50, 16'd0}),
    .REGION_LAST({16'd200, 16'd100})
  ) u_ovl (
    .lbs_clk(clk), .rst_n(rst_n), .lbs_addr(o_addr), .lbs_din(o_din),
    .lbs_we(o_we), .lbs_re(o_re), .lbs_dout(o_dout), .lbs_rvalid(o_rvalid),
    .reg_we(o_reg_we), .reg_re(o_reg_re), .reg_addr(o_reg_addr), .reg_wdata(o_reg_wdata),
    .reg_rdata(o_rdata), .err_irq(o_irq)
  );

  // ---------------- scoreboard ----------------
  int n_chk = 0;
  int n_fail = 0;
  logic [31:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // ---------------- driver ----------------
  logic [3:0]  s_we, s_re;
  logic [15:0] s_addr;
  logic [31:0] s_wdata, s_dout;
  logic        s_rvalid;

  // One access: drive on a falling edge, sample strobes one cycle later,
  // sample read data the cycle after that
  task automatic bus_op(input logic we, input logic re, input logic [15:0] addr,
                        input logic [31:0] din);
    @(negedge clk);
    lbs_we = we; lbs_re = re; lbs_addr = addr; lbs_din = din;
    @(negedge clk);
    lbs_we = 1'b0; lbs_re = 1'b0;
    s_we = reg_we; s_re = reg_re; s_addr = reg_addr; s_wdata = reg_wdata;
    @(negedge clk);
    s_dout = lbs_dout; s_rvalid = lbs_rvalid;
  endtask

  // Read and check the data against the next expected queue entry
  task automatic read_chk(input string tag, input logic [15:0] addr);
    logic [31:0] e;
    bus_op(1'b0, 1'b1, addr, '0);
    e = exp_q.pop_front();
    check(tag, s_dout, e);
    check({tag, "_rvalid"}, {31'b0, s_rvalid}, 32'd1);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    repeat (2) @(negedge clk);
    check("rst_dout", lbs_dout, 32'h0);
    check("rst_misc", {lbs_rvalid, err_irq, reg_we, reg_re}, 32'h0);
    check("rst_addr", {reg_addr, 16'h0}, 32'h0);
    check("rst_wdata", reg_wdata, 32'h0);
    rst_n = 1'b1;

    exp_q.push_back(32'h0007_0000); read_chk("rst_status", 16'hFF03);
    exp_q.push_back(32'h0000_0000); read_chk("rst_scratch", 16'hFF01);
    exp_q.push_back(32'h4C42_5301); read_chk("id", 16'hFF00);

    // Region read with offset
    exp_q.push_back(32'hA200_0005); read_chk("rd12005", 16'd12005);
    check("rd12005_re", {28'b0, s_re}, 32'h4);
    check("rd12005_addr", {16'b0, s_addr}, 32'd5);

    // SCRATCH write/read, no client strobes
    bus_op(1'b1, 1'b0, 16'hFF01, 32'h1234_5678);
    check("scr_wr_we", {28'b0, s_we}, 32'h0);
    check("scr_wr_rvalid", {31'b0, s_rvalid}, 32'h0);
    exp_q.push_back(32'h1234_5678); read_chk("scr_rd", 16'hFF01);
    check("scr_rd_re", {28'b0, s_re}, 32'h0);

    // Region write
    bus_op(1'b1, 1'b0, 16'd16000, 32'h0000_CAFE);
    check("wr16000_we", {28'b0, s_we}, 32'h8);
    check("wr16000_addr", {16'b0, s_addr}, 32'h0);
    check("wr16000_wdata", s_wdata, 32'h0000_CAFE);

    // Unmapped reads
    for (int i = 0; i < 3; i++) begin
      exp_q.push_back(32'h0); read_chk("unmapped_rd", 16'd20000);
      check("unmapped_re", {28'b0, s_re}, 32'h0);
    end
    exp_q.push_back(CNT_EN ? 32'd3 : 32'd0); read_chk("errcnt3", 16'hFF02);
    exp_q.push_back(32'h0007_0001); read_chk("status_unm", 16'hFF03);
    check("irq_masked", {31'b0, err_irq}, 32'h0);
    bus_op(1'b1, 1'b0, 16'hFF03, 32'h0006_0000);
    check("irq_unmasked", {31'b0, err_irq}, 32'h1);
    bus_op(1'b1, 1'b0, 16'hFF03, 32'h0006_0001);
    check("irq_w1c", {31'b0, err_irq}, 32'h0);
    bus_op(1'b1, 1'b0, 16'hFF02, 32'h0);
    exp_q.push_back(32'h0); read_chk("errcnt_clr", 16'hFF02);

    // Simultaneous we and re
    bus_op(1'b1, 1'b1, 16'd11521, 32'h0000_0055);
    check("wr_rd_we", {28'b0, s_we}, 32'h2);
    check("wr_rd_re", {28'b0, s_re}, 32'h2);
    check("wr_rd_dout", s_dout, 32'hA100_0000);
    check("wr_rd_rvalid", {31'b0, s_rvalid}, 32'h1);
    exp_q.push_back(32'h0006_0004); read_chk("status_wr_rd", 16'hFF03);
    check("irq_bit2_masked", {31'b0, err_irq}, 32'h0);

    // Set beats W1C: we+re on STATUS clearing bit 2 while the same access sets it
    bus_op(1'b1, 1'b1, 16'hFF03, 32'h0006_0004);
    check("set_wins", s_dout, 32'h0006_0004);

    // Back-to-back reads
    @(negedge clk); lbs_re = 1'b1; lbs_addr = 16'd0;
    @(negedge clk); lbs_addr = 16'd14304;
    @(negedge clk); lbs_re = 1'b0;
    check("b2b_first", lbs_dout, 32'hA000_0000);
    check("b2b_first_rvalid", {31'b0, lbs_rvalid}, 32'h1);
    @(negedge clk);
    check("b2b_second", lbs_dout, 32'hA200_0900);
    check("b2b_second_rvalid", {31'b0, lbs_rvalid}, 32'h1);
    @(negedge clk);
    check("b2b_idle_rvalid", {31'b0, lbs_rvalid}, 32'h0);

    // Overlapping regions on the second instance
    @(negedge clk); o_re = 1'b1; o_addr = 16'd60;
    @(negedge clk); o_re = 1'b0;
    check("ovl_re", {30'b0, o_reg_re}, 32'h1);
    check("ovl_addr", {16'b0, o_reg_addr}, 32'd60);
    @(negedge clk);
    check("ovl_dout", o_dout, 32'hB0B0_B0B0);
    @(negedge clk); o_re = 1'b1; o_addr = 16'hFF03;
    @(negedge clk); o_re = 1'b0;
    @(negedge clk);
    check("ovl_status", o_dout, 32'h0007_0002);

    // Reset in the middle of a read: strobe and return are dropped
    @(negedge clk); lbs_re = 1'b1; lbs_addr = 16'd12005;
    @(negedge clk); lbs_re = 1'b0;
    check("mid_pre_re", {28'b0, reg_re}, 32'h4);
    rst_n = 1'b0;
    #1;
    check("mid_rst_re", {28'b0, reg_re}, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    check("mid_rst_rvalid", {31'b0, lbs_rvalid}, 32'h0);
    @(negedge clk);
    check("mid_after_rvalid", {31'b0, lbs_rvalid}, 32'h0);
    check("mid_after_dout", lbs_dout, 32'h0);

`ifdef LBS_MUX_ERR_CNT_EN
    // Saturation of the unmapped counter
    @(negedge clk); lbs_we = 1'b1; lbs_addr = 16'd20000; lbs_din = '0;
    repeat (70000) @(negedge clk);
    lbs_we = 1'b0;
    exp_q.push_back(32'h0000_FFFF); read_chk("errcnt_sat", 16'hFF02);
`else
    bus_op(1'b0, 1'b1, 16'd20000, '0);
    exp_q.push_back(32'h0); read_chk("errcnt_absent", 16'hFF02);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
